// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Holds the controller state encoding and the byte-lane helpers.
package dcache_pkg;

  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 32;
  localparam int NBLK    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk, input logic [OFF_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [BLOCK_W-1:0] set_byte(input logic [BLOCK_W-1:0] blk, input logic [OFF_W-1:0] off,
                                                  input logic [7:0] b);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[{off, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/dcache_chk.sv
// Protocol checker for the cache memory port: read and write requests are exclusive.
module dcache_chk (
  input logic CLK,
  input logic RESET,
  input logic MEM_READ,
  input logic MEM_WRITE
);

  mem_req_exclusive_a: assert property (@(posedge CLK) !(MEM_READ && MEM_WRITE));

  // Catch overlap even when it glitches between clock edges
  always_comb begin
    if (!RESET) begin
      mem_req_exclusive_c: assert (!(MEM_READ && MEM_WRITE));
    end else begin
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Miss controller: sequences write-back of a dirty victim and the block fetch.
// Memory-side outputs are registered; the fill strobe is combinational so the block
// lands on the same edge that ends the fetch.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               miss_s,
  input  logic               dirty_s,
  input  logic [TAG_W-1:0]   req_tag_s,
  input  logic [IDX_W-1:0]   req_idx_s,
  input  logic [TAG_W-1:0]   old_tag_s,
  input  logic [BLOCK_W-1:0] old_block_s,
  input  logic               MEM_BUSYWAIT,
  output state_t             state_r,
  output logic               mem_read_r,
  output logic               mem_write_r,
  output logic [5:0]         mem_address_r,
  output logic [BLOCK_W-1:0] mem_writedata_r,
  output logic               fill_s,
  output logic [TAG_W-1:0]   fill_tag_r,
  output logic [IDX_W-1:0]   fill_idx_r
);

  assign fill_s = (state_r == FETCH) && !MEM_BUSYWAIT;

  // Miss FSM with registered memory request outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r         <= IDLE;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_address_r   <= 6'd0;
      mem_writedata_r <= 32'd0;
      fill_tag_r      <= 3'd0;
      fill_idx_r      <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            fill_tag_r <= req_tag_s;
            fill_idx_r <= req_idx_s;
            if (dirty_s) begin
              state_r         <= WRITEBACK;
              mem_write_r     <= 1'b1;
              mem_address_r   <= {old_tag_s, req_idx_s};
              mem_writedata_r <= old_block_s;
            end else begin
              state_r       <= FETCH;
              mem_read_r    <= 1'b1;
              mem_address_r <= {req_tag_s, req_idx_s};
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state_r         <= FETCH;
            mem_write_r     <= 1'b0;
            mem_read_r      <= 1'b1;
            mem_address_r   <= {fill_tag_r, fill_idx_r};
            mem_writedata_r <= 32'd0;
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state_r       <= IDLE;
            mem_read_r    <= 1'b0;
            mem_address_r <= 6'd0;
          end
        end
        default: begin
          state_r         <= IDLE;
          mem_read_r      <= 1'b0;
          mem_write_r     <= 1'b0;
          mem_address_r   <= 6'd0;
          mem_writedata_r <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped 8 x 4-byte write-back, write-allocate data cache.
// Tag/data/valid/dirty arrays and hit detection live here; dcache_ctrl runs misses.
module dcache
  import dcache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  logic [BLOCK_W-1:0] data_r [0:NBLK-1];
  logic [TAG_W-1:0]   tag_r  [0:NBLK-1];
  logic [NBLK-1:0]    valid_r;
  logic [NBLK-1:0]    dirty_r;

  logic [TAG_W-1:0] tag_s;
  logic [IDX_W-1:0] idx_s;
  logic [OFF_W-1:0] off_s;
  logic             req_s, hit_s, idle_s, miss_s, write_hit_s;
  state_t           state_s;
  logic             fill_s;
  logic [TAG_W-1:0] fill_tag_s;
  logic [IDX_W-1:0] fill_idx_s;

  assign tag_s = ADDRESS[7:5];
  assign idx_s = ADDRESS[4:2];
  assign off_s = ADDRESS[1:0];

  // Hit detection and the zero-stall CPU response
  always_comb begin
    req_s       = READ | WRITE;
    hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    idle_s      = (state_s == IDLE);
    miss_s      = req_s && !hit_s && idle_s;
    write_hit_s = WRITE && hit_s && idle_s;
    BUSYWAIT    = 1'b0;
    READDATA    = 8'h00;
    if (RESET) begin
      BUSYWAIT = 1'b0;
      READDATA = 8'h00;
    end else begin
      BUSYWAIT = req_s && (!idle_s || !hit_s);
      if (READ && hit_s && idle_s) begin
        READDATA = get_byte(data_r[idx_s], off_s);
      end else begin
        READDATA = 8'h00;
      end
    end
  end

  // Valid and dirty bits; cleared asynchronously so reset invalidates everything
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_r <= 8'h00;
      dirty_r <= 8'h00;
    end else if (fill_s) begin
      valid_r[fill_idx_s] <= 1'b1;
      dirty_r[fill_idx_s] <= 1'b0;
    end else if (write_hit_s) begin
      dirty_r[idx_s] <= 1'b1;
    end
  end

  // Data and tag arrays; contents are don't-care until the valid bit is set
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      data_r[fill_idx_s] <= MEM_READDATA;
      tag_r[fill_idx_s]  <= fill_tag_s;
    end else if (write_hit_s) begin
      data_r[idx_s] <= set_byte(data_r[idx_s], off_s, WRITEDATA);
    end
  end

  dcache_ctrl u_ctrl (
    .CLK             (CLK),
    .RESET           (RESET),
    .miss_s          (miss_s),
    .dirty_s         (dirty_r[idx_s]),
    .req_tag_s       (tag_s),
    .req_idx_s       (idx_s),
    .old_tag_s       (tag_r[idx_s]),
    .old_block_s     (data_r[idx_s]),
    .MEM_BUSYWAIT    (MEM_BUSYWAIT),
    .state_r         (state_s),
    .mem_read_r      (MEM_READ),
    .mem_write_r     (MEM_WRITE),
    .mem_address_r   (MEM_ADDRESS),
    .mem_writedata_r (MEM_WRITEDATA),
    .fill_s          (fill_s),
    .fill_tag_r      (fill_tag_s),
    .fill_idx_r      (fill_idx_s)
  );

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: table of CPU accesses with a scoreboard queue,
// a behavioural main memory (5 busy cycles per transaction) and hand-written corner cases.
module tb_dcache;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  always #5 CLK = ~CLK;

  dcache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  dcache_chk u_chk (.CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE));

  // Main memory: byte at address a holds a, except block 0x01 = DDCCBBAA
  localparam int MEM_LAT = 5;
  logic [31:0] mem [0:63];
  int          mcnt = 0;
  bit          mem_init = 1'b0;

  assign MEM_READDATA = mem[MEM_ADDRESS];
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt != MEM_LAT);

  always @(posedge CLK or posedge RESET) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)};
      end
      mem[1]   <= 32'hDDCCBBAA;
      mem_init <= 1'b1;
      mcnt     <= 0;
    end else if (RESET) begin
      mcnt <= 0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (mcnt == MEM_LAT) begin
        mcnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Memory-port monitor: counts request starts and records their address/data
  int          rd_cnt = 0, wr_cnt = 0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [5:0]  last_rd_addr = 6'd0, last_wb_addr = 6'd0;
  logic [31:0] last_wb_data = 32'd0;

  always @(posedge CLK) begin
    prev_rd <= MEM_READ;
    prev_wr <= MEM_WRITE;
    if (MEM_READ && !prev_rd) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= MEM_ADDRESS;
    end
    if (MEM_WRITE && !prev_wr) begin
      wr_cnt       <= wr_cnt + 1;
      last_wb_addr <= MEM_ADDRESS;
      last_wb_data <= MEM_WRITEDATA;
    end
  end

  typedef struct {
    logic        rd, wr;
    logic [7:0]  addr, wdata, exp_data;
    int          exp_busy, exp_nrd, exp_nwr;
    logic [5:0]  rd_addr, wb_addr;
    logic [31:0] wb_data;
  } vec_t;

  vec_t vecs [0:12];
  vec_t sb [$];
  int   n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic [7:0] exp_data, input int busy, input int nrd, input logic [5:0] rda,
                               input int nwr, input logic [5:0] wba, input logic [31:0] wbd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_data = exp_data;
    v.exp_busy = busy; v.exp_nrd = nrd; v.rd_addr = rda; v.exp_nwr = nwr;
    v.wb_addr = wba; v.wb_data = wbd;
    return v;
  endfunction

  task automatic run(input string nm, input vec_t v);
    int   busy, r0, w0;
    vec_t e;
    @(negedge CLK);
    r0 = rd_cnt; w0 = wr_cnt;
    READ = v.rd; WRITE = v.wr; ADDRESS = v.addr; WRITEDATA = v.wdata;
    sb.push_back(v);
    #1;
    busy = 0;
    while (BUSYWAIT && busy < 200) begin
      busy++;
      @(negedge CLK);
      #1;
    end
    e = sb.pop_front();
    chk({nm, " busy"}, busy, e.exp_busy);
    if (!(e.rd && e.wr)) chk({nm, " readdata"}, {24'd0, READDATA}, {24'd0, e.exp_data});
    chk({nm, " fetches"}, rd_cnt - r0, e.exp_nrd);
    chk({nm, " writebacks"}, wr_cnt - w0, e.exp_nwr);
    if (e.exp_nrd > 0) chk({nm, " fetch addr"}, {26'd0, last_rd_addr}, {26'd0, e.rd_addr});
    if (e.exp_nwr > 0) begin
      chk({nm, " wb addr"}, {26'd0, last_wb_addr}, {26'd0, e.wb_addr});
      chk({nm, " wb data"}, last_wb_data, e.wb_data);
    end
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    int n;
    //            rd    wr    addr   wdata  data   busy nrd rda    nwr wba    wbdata
    vecs[0]  = mkv(1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, 7,  1, 6'h01, 0, 6'h00, 32'h0);
    vecs[1]  = mkv(1'b1, 1'b0, 8'h06, 8'h00, 8'hCC, 0,  0, 6'h00, 0, 6'h00, 32'h0);
    vecs[2]  = mkv(1'b0, 1'b1, 8'h05, 8'h55, 8'h00, 0,  0, 6'h00, 0, 6'h00, 32'h0);
    vecs[3]  = mkv(1'b1, 1'b0, 8'h25, 8'h00, 8'h25, 13, 1, 6'h09, 1, 6'h01, 32'hDDCC55AA);
    vecs[4]  = mkv(1'b1, 1'b0, 8'h05, 8'h00, 8'h55, 7,  1, 6'h01, 0, 6'h00, 32'h0);
    vecs[5]  = mkv(1'b1, 1'b1, 8'h04, 8'h77, 8'h00, 0,  0, 6'h00, 0, 6'h00, 32'h0);
    vecs[6]  = mkv(1'b1, 1'b0, 8'h04, 8'h00, 8'h77, 0,  0, 6'h00, 0, 6'h00, 32'h0);
    vecs[7]  = mkv(1'b1, 1'b0, 8'h07, 8'h00, 8'hDD, 0,  0, 6'h00, 0, 6'h00, 32'h0);
    vecs[8]  = mkv(1'b1, 1'b0, 8'h08, 8'h00, 8'h08, 7,  1, 6'h02, 0, 6'h00, 32'h0);
    vecs[9]  = mkv(1'b0, 1'b1, 8'hE8, 8'h99, 8'h00, 7,  1, 6'h3A, 0, 6'h00, 32'h0);
    vecs[10] = mkv(1'b1, 1'b0, 8'h08, 8'h00, 8'h08, 13, 1, 6'h02, 1, 6'h3A, 32'hEBEAE999);
    vecs[11] = mkv(1'b1, 1'b0, 8'hEB, 8'h00, 8'hEB, 7,  1, 6'h3A, 0, 6'h00, 32'h0);
    vecs[12] = mkv(1'b1, 1'b0, 8'hE8, 8'h00, 8'h99, 0,  0, 6'h00, 0, 6'h00, 32'h0);

    // Reset state, with a read request held so outputs must be forced low
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h05; WRITEDATA = 8'h00;
    @(negedge CLK); @(negedge CLK); #1;
    chk("reset busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("reset mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("reset mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("reset readdata", {24'd0, READDATA}, 32'd0);
    chk("reset mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    chk("reset mem_writedata", MEM_WRITEDATA, 32'd0);
    @(negedge CLK);
    READ = 1'b0; RESET = 1'b0;

    for (int i = 0; i < 13; i++) run($sformatf("vec%0d", i), vecs[i]);

    // Request withdrawn mid-fetch: stall drops at once, block still installed
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h30;
    #1 chk("withdraw miss busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK); @(negedge CLK);
    READ = 1'b0;
    #1 chk("withdraw busy low", {31'd0, BUSYWAIT}, 32'd0);
    n = 0;
    while (MEM_READ && n < 50) begin n++; @(negedge CLK); #1; end
    chk("withdraw fetch done", {31'd0, MEM_READ}, 32'd0);
    run("withdraw hit", mkv(1'b1, 1'b0, 8'h30, 8'h00, 8'h30, 0, 0, 6'h00, 0, 6'h00, 32'h0));

    // Reset during a fetch abandons it and invalidates the cache
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h50;
    @(negedge CLK); @(negedge CLK); #1;
    chk("pre-reset fetching", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("midreset mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("midreset busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("midreset mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0; READ = 1'b0;
    run("post-reset miss", mkv(1'b1, 1'b0, 8'h05, 8'h00, 8'h55, 7, 1, 6'h01, 0, 6'h00, 32'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
